fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Upstream partner of control_unit. Owns the PC, fetches from synchronous instruction
//  memory and drives the opcode that control_unit decodes.
//  Consumes pc_selector/halt back from control_unit and sequences each instruction.
//  Gates architectural writes through exec_enable and stalls IN instructions until a
//  user-input handshake completes.
// PARAMETERS
//  PC_WIDTH      10  instruction address width; branch/jump target = instruction[PC_WIDTH-1:0]
//  INSTR_WIDTH   32  instruction word width; opcode = instruction[INSTR_WIDTH-1 -: 5]
//  COUNT_WIDTH   16  width of retired-instruction counter
// PORTS
//  clock          in   1            single clock, rising edge
//  reset          in   1            asynchronous, active-low
//  instr_addr     out  PC_WIDTH     instruction memory address (= pc)
//  instr_data     in   INSTR_WIDTH  instruction memory data, valid one cycle after address
//  instruction    out  INSTR_WIDTH  instruction register, feeds decode/immediate paths
//  opcode         out  5            instruction[top 5 bits], to control_unit
//  pc_selector    in   1            from control_unit: 1 = take target, 0 = pc+1
//  halt           in   1            from control_unit: stop execution
//  input_valid    in   1            user confirms input switches are ready (level)
//  input_ack      out  1            one-cycle pulse: IN instruction consumed input
//  exec_enable    out  1            qualifies register/memory/output writes this cycle
//  halted         out  1            sequencer is in HALTED
//  pc             out  PC_WIDTH     current program counter
//  retired_count  out  COUNT_WIDTH  instructions completed, saturating
// BEHAVIOUR
//  - Reset (reset=0, async): pc=0, state=FETCH, instruction=NOP (5'b00100, rest 0),
//    exec_enable=0, input_ack=0, halted=0, retired_count=0. Takes effect immediately.
//  - instr_addr = pc (combinational).
//  - FSM states: FETCH, DECODE, EXEC, WAIT_IN, HALTED.
//  - FETCH: 1 cycle; memory samples instr_addr; -> DECODE.
//  - DECODE: instruction <= instr_data at end of cycle; -> EXEC.
//  - EXEC: opcode valid for the whole cycle. Priority order:
//    1. halt=1: -> HALTED; pc unchanged; exec_enable=0.
//    2. opcode==IN: -> WAIT_IN; exec_enable=0; pc unchanged.
//    3. Otherwise: exec_enable=1; pc <= pc_selector ? instruction[PC_WIDTH-1:0] : pc+1; -> FETCH.
//  - WAIT_IN: exec_enable=input_valid, input_ack=input_valid. On input_valid:
//    pc <= pc+1; -> FETCH. Otherwise hold.
//  - HALTED: exec_enable=0, halted=1. Absorbing state; only reset leaves it.
//  - Latency: 3 cycles per instruction; IN takes 3 + wait cycles, with a 4-cycle minimum.
//  - pc arithmetic is modulo 2^PC_WIDTH: pc=all-ones with pc+1 wraps to 0.
//  - retired_count: +1 on every cycle with exec_enable=1; holds at all-ones.
//  - input_valid outside WAIT_IN: ignored.
//  - input_valid held high: exactly one input_ack per IN instruction. A following IN
//    still passes through EXEC, then WAIT_IN.
//  - halt together with pc_selector: halt wins, pc frozen.
//  - Reset during WAIT_IN or HALTED: returns to FETCH at pc=0; no input_ack emitted.
//  - exec_enable and input_ack are never asserted in FETCH, DECODE or HALTED.
// STRUCTURE
//  - Shared package/include processor_defs: opcode constants (OP_NOP=5'b00100,
//    OP_HALT=5'b00101, OP_JUMP=5'b00110, OP_IN=5'b01100), and FSM state encoding
//    (3-bit localparams). control_unit is to be migrated to the same opcode constants.
//  - One sub-module, program_counter: pc register with async active-low reset, load
//    enable, select between target and increment, wrap-around.
//  - FSM, instruction register and retired counter stay in fetch_sequencer.
// TESTING
//  1. Reset release, memory[0..2]=add,add,nop -> pc 0->1->2->3 on cycles 3,6,9;
//     exec_enable pulses once per 3 cycles; retired_count=3.
//  2. Jump at pc=5 with target 0x040, pc_selector=1 -> next instr_addr=0x040;
//     cycle count unchanged.
//  3. IN at pc=7, input_valid low for 10 cycles, then high -> WAIT_IN held 10 cycles;
//     single input_ack coinciding with exec_enable; pc=8.
//  4. HALT at pc=3 (halt=1) -> halted=1, pc stays 3, no exec_enable for 50 cycles.
//     Then reset pulse -> pc=0, halted=0.
//  5. pc=0x3FF, non-branch instruction -> pc wraps to 0x000.
//     Preload retired_count near max -> saturates at 0xFFFF.
//  6. Reset asserted mid-WAIT_IN while input_valid=1 -> input_ack stays 0,
//     state FETCH, instruction=NOP.

Source files
------------

// File: rtl/processor_defs_pkg.sv
// Opcode constants and sequencer state encoding shared by fetch_sequencer and
// control_unit, so both sides agree on what each opcode means.
package processor_defs;

    localparam logic [4:0] OP_NOP  = 5'b00100;
    localparam logic [4:0] OP_HALT = 5'b00101;
    localparam logic [4:0] OP_JUMP = 5'b00110;
    localparam logic [4:0] OP_IN   = 5'b01100;

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_WAIT_IN = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_EXEC    = ST_EXEC,
        S_WAIT_IN = ST_WAIT_IN,
        S_HALTED  = ST_HALTED
    } seq_state_e;

    function automatic logic is_in_op(input logic [4:0] op);
        return op == OP_IN;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc.sv
// Program counter: loads either a branch target or pc+1 when enabled.
// Increment is modulo 2^PC_WIDTH, so the all-ones address wraps to zero.
module program_counter #(
    parameter int PC_WIDTH = 10
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                load_i,
    input  logic                sel_target_i,
    input  logic [PC_WIDTH-1:0] target_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = sel_target_i ? target_i : pc_q + 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q <= '0;
        end else if (load_i) begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: fetch/decode/execute FSM in front of control_unit,
// with an input-handshake stall for IN and a saturating retired counter.
module fetch_sequencer
    import processor_defs::*;
#(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    instr_addr,
    input  logic [INSTR_WIDTH-1:0] instr_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [4:0]             opcode,
    input  logic                   pc_selector,
    input  logic                   halt,
    input  logic                   input_valid,
    output logic                   input_ack,
    output logic                   exec_enable,
    output logic                   halted,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = {OP_NOP, {(INSTR_WIDTH-5){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};

    seq_state_e             state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   exec_en;
    logic                   ack;
    logic                   pc_load;
    logic                   pc_sel;
    logic [PC_WIDTH-1:0]    pc_w;

    program_counter #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc (
        .clock_i      (clock),
        .reset_ni     (reset),
        .load_i       (pc_load),
        .sel_target_i (pc_sel),
        .target_i     (instr_q[PC_WIDTH-1:0]),
        .pc_o         (pc_w)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        exec_en = 1'b0;
        ack     = 1'b0;
        pc_load = 1'b0;
        pc_sel  = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                instr_d = instr_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // halt outranks both IN and a taken branch: pc stays frozen
                if (halt) begin
                    state_d = S_HALTED;
                end else if (is_in_op(instr_q[INSTR_WIDTH-1 -: 5])) begin
                    state_d = S_WAIT_IN;
                end else begin
                    exec_en = 1'b1;
                    pc_load = 1'b1;
                    pc_sel  = pc_selector;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_IN: begin
                if (input_valid) begin
                    exec_en = 1'b1;
                    ack     = 1'b1;
                    pc_load = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (exec_en && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            instr_q <= NOP_WORD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_addr    = pc_w;
    assign pc            = pc_w;
    assign instruction   = instr_q;
    assign opcode        = instr_q[INSTR_WIDTH-1 -: 5];
    assign exec_enable   = exec_en;
    assign input_ack     = ack;
    assign halted        = (state_q == S_HALTED);
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios followed by a random program, checked against an
// instruction-level model of pc flow, stall lengths and retirement.
module tb_fetch_sequencer;
    import processor_defs::*;

    localparam int PW = 10;
    localparam int IW = 32;
    localparam int CW = 8;
    localparam int CMAX = 255;
    localparam logic [4:0] OP_ADD = 5'b00001;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] instr_addr;
    logic [IW-1:0] instr_data;
    logic [IW-1:0] instruction;
    logic [4:0]    opcode;
    logic          pc_selector;
    logic          halt;
    logic          input_valid = 1'b0;
    logic          input_ack;
    logic          exec_enable;
    logic          halted;
    logic [PW-1:0] pc;
    logic [CW-1:0] retired_count;

    int total = 0;
    int bad   = 0;
    int pc_m  = 0;
    int cnt_m = 0;
    logic [IW-1:0] mem [0:1023];

    fetch_sequencer #(
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_addr    (instr_addr),
        .instr_data    (instr_data),
        .instruction   (instruction),
        .opcode        (opcode),
        .pc_selector   (pc_selector),
        .halt          (halt),
        .input_valid   (input_valid),
        .input_ack     (input_ack),
        .exec_enable   (exec_enable),
        .halted        (halted),
        .pc            (pc),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) instr_data <= mem[instr_addr];

    // Stand-in for control_unit; HALT also raises pc_selector to show halt wins.
    assign halt        = (opcode == OP_HALT);
    assign pc_selector = (opcode == OP_JUMP) || (opcode == OP_HALT);

    function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [PW-1:0] tgt);
        logic [16:0] mid;
        mid = 17'($urandom);
        return {op, mid, tgt};
    endfunction

    function automatic int sat(input int c);
        return (c > CMAX) ? CMAX : c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_addr", 32'(instr_addr), 32'd0);
        chk("rst_instr", instruction, {OP_NOP, 27'd0});
        chk("rst_op", 32'(opcode), 32'(OP_NOP));
        chk("rst_en", 32'(exec_enable), 32'd0);
        chk("rst_ack", 32'(input_ack), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(retired_count), 32'd0);
    endtask

    // Runs one instruction from mid-FETCH; wait_cyc<0 keeps input_valid high throughout.
    task automatic run_instr(input int wait_cyc);
        logic [IW-1:0] w;
        logic [4:0]    op;
        logic          held;
        held = (wait_cyc < 0);
        w    = mem[pc_m];
        op   = w[IW-1 -: 5];
        input_valid = held ? 1'b1 : 1'($urandom);
        settle();
        chk("f_addr", 32'(instr_addr), 32'(pc_m));
        chk("f_en", 32'(exec_enable), 32'd0);
        chk("f_ack", 32'(input_ack), 32'd0);
        chk("f_halted", 32'(halted), 32'd0);
        tick();
        input_valid = held ? 1'b1 : 1'($urandom);
        settle();
        chk("d_en", 32'(exec_enable), 32'd0);
        chk("d_ack", 32'(input_ack), 32'd0);
        tick();
        input_valid = held ? 1'b1 : 1'($urandom);
        settle();
        chk("e_op", 32'(opcode), 32'(op));
        chk("e_instr", instruction, w);
        chk("e_en", 32'(exec_enable), 32'(op != OP_HALT && op != OP_IN));
        chk("e_ack", 32'(input_ack), 32'd0);
        if (op == OP_HALT) begin
            for (int k = 0; k < 50; k++) begin
                tick();
                input_valid = 1'($urandom);
                settle();
                chk("h_halted", 32'(halted), 32'd1);
                chk("h_en", 32'(exec_enable), 32'd0);
                chk("h_ack", 32'(input_ack), 32'd0);
                chk("h_pc", 32'(pc), 32'(pc_m));
            end
            return;
        end
        if (op == OP_IN) begin
            for (int k = 0; k < wait_cyc; k++) begin
                tick();
                input_valid = 1'b0;
                settle();
                chk("w_en", 32'(exec_enable), 32'd0);
                chk("w_ack", 32'(input_ack), 32'd0);
                chk("w_pc", 32'(pc), 32'(pc_m));
            end
            tick();
            input_valid = 1'b1;
            settle();
            chk("w_en_go", 32'(exec_enable), 32'd1);
            chk("w_ack_go", 32'(input_ack), 32'd1);
            cnt_m++;
            tick();
            pc_m = (pc_m + 1) % 1024;
        end else begin
            cnt_m++;
            tick();
            pc_m = (op == OP_JUMP) ? int'(w[PW-1:0]) : (pc_m + 1) % 1024;
        end
        chk("next_pc", 32'(pc), 32'(pc_m));
        chk("retired", 32'(retired_count), 32'(sat(cnt_m)));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {OP_NOP, 27'd0};
        mem[0] = mk(OP_ADD, 10'h0);
        mem[1] = mk(OP_ADD, 10'h0);
        mem[2] = mk(OP_NOP, 10'h0);
        mem[3] = mk(OP_HALT, 10'h155);

        repeat (3) tick();
        check_reset_state();
        reset = 1'b1;
        pc_m  = 0;
        cnt_m = 0;
        for (int i = 0; i < 4; i++) run_instr(0);
        chk("halt_cnt", 32'(retired_count), 32'd3);

        // Asynchronous reset out of HALTED takes effect before the next edge.
        reset = 1'b0;
        settle();
        check_reset_state();
        tick();
        reset = 1'b1;
        pc_m  = 0;
        cnt_m = 0;

        for (int i = 0; i < 5; i++) mem[i] = mk(OP_ADD, 10'($urandom));
        mem[5]      = mk(OP_JUMP, 10'h040);
        mem[10'h40] = mk(OP_JUMP, 10'h007);
        mem[7]      = mk(OP_IN, 10'h0);
        mem[8]      = mk(OP_IN, 10'h0);
        mem[9]      = mk(OP_JUMP, 10'h3FF);
        mem[10'h3FF] = mk(OP_ADD, 10'h123);
        for (int i = 0; i < 6; i++) run_instr(0);
        chk("jump_pc", 32'(pc), 32'h040);
        run_instr(0);
        run_instr(10);
        chk("in_pc", 32'(pc), 32'd8);
        run_instr(-1);
        run_instr(0);
        run_instr(0);
        chk("wrap_pc", 32'(pc), 32'd0);

        // Reset while stalled in WAIT_IN with input_valid rising at the same time.
        mem[1] = mk(OP_IN, 10'h0);
        run_instr(0);
        input_valid = 1'b0;
        repeat (5) tick();
        chk("wi_en", 32'(exec_enable), 32'd0);
        chk("wi_pc", 32'(pc), 32'd1);
        input_valid = 1'b1;
        reset = 1'b0;
        settle();
        chk("wi_rst_ack", 32'(input_ack), 32'd0);
        check_reset_state();
        tick();
        chk("wi_rst_ack2", 32'(input_ack), 32'd0);
        reset = 1'b1;
        input_valid = 1'b0;
        pc_m  = 0;
        cnt_m = 0;

        for (int i = 0; i < 1024; i++) begin
            int r;
            logic [4:0] op;
            r = int'($urandom_range(0, 3));
            if (r == 0) op = OP_IN;
            else if (r == 1) op = OP_JUMP;
            else begin
                op = 5'($urandom);
                while (op == OP_HALT || op == OP_IN || op == OP_JUMP) op = 5'($urandom);
            end
            mem[i] = mk(op, 10'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) run_instr(-1);
            else run_instr(int'($urandom_range(0, 4)));
        end
        chk("sat_cnt", 32'(retired_count), 32'(CMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
